vga_capture: RTL



---
 rtl/vga_capture_pkg.sv | 32 +++
 rtl/vga_sync_edge.sv | 51 +++++
 rtl/vga_capture.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/vga_capture_pkg.sv
// Shared 640x480@60 VGA timing constants and lock-FSM types.
// The transmitter and the capture side both take their geometry from here.
package vga_capture_pkg;

   localparam int H_VISIBLE_AREA = 640;
   localparam int H_FRONT_PORCH  = 16;
   localparam int H_SYNC_PULSE   = 96;
   localparam int H_BACK_PORCH   = 48;
   localparam int V_VISIBLE_AREA = 480;
   localparam int V_FRONT_PORCH  = 10;
   localparam int V_SYNC_PULSE   = 2;
   localparam int V_BACK_PORCH   = 33;
   localparam int LOCK_LINES     = 4;

   localparam int H_TOTAL  = H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
   localparam int V_TOTAL  = V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
   localparam int HS_START = H_VISIBLE_AREA + H_FRONT_PORCH;
   localparam int VS_START = V_VISIBLE_AREA + V_FRONT_PORCH;

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_HUNT     = 2'd1,
      ST_LOCKED   = 2'd2
   } lock_state_t;

   // 3:3:3 colour from the top bits of each 8-bit channel
   function automatic logic [8:0] pack_rgb(input logic [7:0] r, input logic [7:0] g,
                                           input logic [7:0] b);
      return {r[7:5], g[7:5], b[7:5]};
   endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Input sampling stage: registers the VGA pins (s1), keeps the previous sync
// levels (s2) and flags falling edges of hSync/vSync on the s1 sample.
module vga_sync_edge
   import vga_capture_pkg::*;
(
   input  logic       clk25,
   input  logic       rst_n,
   input  logic       hSync,
   input  logic       vSync,
   input  logic [7:0] red,
   input  logic [7:0] green,
   input  logic [7:0] blue,
   output logic       hs_fall,
   output logic       vs_fall,
   output logic [8:0] rgb_p1
);

   logic       hsync_p1, hsync_p2;
   logic       vsync_p1, vsync_p2;
   logic [7:0] red_p1, green_p1, blue_p1;
   logic       unused_low_bits;

   // s1: pin sample, s2: previous sync levels; reset leaves the link idle
   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         hsync_p1 <= 1'b1;
         vsync_p1 <= 1'b1;
         hsync_p2 <= 1'b1;
         vsync_p2 <= 1'b1;
         red_p1   <= '0;
         green_p1 <= '0;
         blue_p1  <= '0;
      end else begin
         hsync_p1 <= hSync;
         vsync_p1 <= vSync;
         hsync_p2 <= hsync_p1;
         vsync_p2 <= vsync_p1;
         red_p1   <= red;
         green_p1 <= green;
         blue_p1  <= blue;
      end
   end

   assign hs_fall = hsync_p2 & ~hsync_p1;
   assign vs_fall = vsync_p2 & ~vsync_p1;
   assign rgb_p1  = pack_rgb(red_p1, green_p1, blue_p1);

   // Only the top three bits of each channel reach the framebuffer
   assign unused_low_bits = ^{red_p1[4:0], green_p1[4:0], blue_p1[4:0]};

endmodule

// File: rtl/vga_capture.sv
// VGA receive side: rebuilds the transmitter's h/v counters from sync edges,
// locks after a run of consistent lines and emits one write strobe per pixel.
module vga_capture #(
   parameter int H_VISIBLE_AREA = vga_capture_pkg::H_VISIBLE_AREA,
   parameter int H_FRONT_PORCH  = vga_capture_pkg::H_FRONT_PORCH,
   parameter int H_SYNC_PULSE   = vga_capture_pkg::H_SYNC_PULSE,
   parameter int H_BACK_PORCH   = vga_capture_pkg::H_BACK_PORCH,
   parameter int V_VISIBLE_AREA = vga_capture_pkg::V_VISIBLE_AREA,
   parameter int V_FRONT_PORCH  = vga_capture_pkg::V_FRONT_PORCH,
   parameter int V_SYNC_PULSE   = vga_capture_pkg::V_SYNC_PULSE,
   parameter int V_BACK_PORCH   = vga_capture_pkg::V_BACK_PORCH,
   parameter int LOCK_LINES     = vga_capture_pkg::LOCK_LINES
) (
   input  logic       clk25,
   input  logic       rst_n,
   input  logic       hSync,
   input  logic       vSync,
   input  logic [7:0] red,
   input  logic [7:0] green,
   input  logic [7:0] blue,
   output logic       pixValid,
   output logic [9:0] pixX,
   output logic [9:0] pixY,
   output logic [8:0] pixRGB,
   output logic       frameStart,
   output logic       locked,
   output logic       syncError
);

   import vga_capture_pkg::*;

   localparam int H_TOT  = H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
   localparam int V_TOT  = V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
   localparam int LOCK_W = $clog2(LOCK_LINES + 1);

   localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
   localparam logic [9:0] HS_POS = 10'(H_VISIBLE_AREA + H_FRONT_PORCH);
   localparam logic [9:0] VS_POS = 10'(V_VISIBLE_AREA + V_FRONT_PORCH);
   localparam logic [9:0] H_VIS  = 10'(H_VISIBLE_AREA);
   localparam logic [9:0] V_VIS  = 10'(V_VISIBLE_AREA);

   logic              hs_fall, vs_fall;
   logic [8:0]        rgb_p1;
   logic [9:0]        h_prev, v_prev;
   logic [9:0]        h_inc, v_inc, h_cur, v_cur;
   logic              hs_err, vs_err, vs_due, timing_err, pix_ok;
   lock_state_t       state, state_nxt;
   logic [LOCK_W-1:0] lock_cnt, lock_nxt;
   logic              vld_p2, fs_p2, err_p2;
   logic [9:0]        x_p2, y_p2;
   logic [8:0]        rgb_p2;

   vga_sync_edge u_sync_edge (
      .clk25   (clk25),
      .rst_n   (rst_n),
      .hSync   (hSync),
      .vSync   (vSync),
      .red     (red),
      .green   (green),
      .blue    (blue),
      .hs_fall (hs_fall),
      .vs_fall (vs_fall),
      .rgb_p1  (rgb_p1)
   );

   // h_prev/v_prev hold the count of the s2 sample; h_cur/v_cur describe s1
   always_comb begin
      h_inc = (h_prev == H_LAST) ? '0 : h_prev + 10'd1;
      v_inc = v_prev;
      if (h_prev == H_LAST) v_inc = (v_prev == V_LAST) ? '0 : v_prev + 10'd1;
      h_cur = h_inc;
      v_cur = v_inc;
      if (hs_fall) h_cur = HS_POS;
      if (vs_fall) begin
         h_cur = '0;
         v_cur = VS_POS;
      end
   end

   // An edge must land exactly where free-running counts expect it, and vice versa
   always_comb begin
      vs_due     = (h_inc == '0) && (v_inc == VS_POS);
      hs_err     = hs_fall ^ (h_inc == HS_POS);
      vs_err     = vs_fall ^ vs_due;
      timing_err = (state != ST_UNLOCKED) && (hs_err || vs_err);
      pix_ok     = (state == ST_LOCKED) && (h_cur < H_VIS) && (v_cur < V_VIS);
   end

   always_comb begin
      state_nxt = state;
      lock_nxt  = lock_cnt;
      case (state)
         ST_UNLOCKED: begin
            if (vs_fall) begin
               state_nxt = ST_HUNT;
               lock_nxt  = '0;
            end
         end
         default: begin
            if (timing_err) begin
               state_nxt = vs_fall ? ST_HUNT : ST_UNLOCKED;
               lock_nxt  = '0;
            end else if (state == ST_HUNT && hs_fall) begin
               lock_nxt = lock_cnt + 1'b1;
               if (lock_nxt == LOCK_W'(LOCK_LINES)) state_nxt = ST_LOCKED;
            end
         end
      endcase
   end

   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_UNLOCKED;
         lock_cnt <= '0;
         h_prev   <= '0;
         v_prev   <= '0;
      end else begin
         state    <= state_nxt;
         lock_cnt <= lock_nxt;
         h_prev   <= h_cur;
         v_prev   <= v_cur;
      end
   end

   // Output stage: pixel fields only move on a strobe so they hold across blanking
   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         vld_p2 <= 1'b0;
         fs_p2  <= 1'b0;
         err_p2 <= 1'b0;
         x_p2   <= '0;
         y_p2   <= '0;
         rgb_p2 <= '0;
      end else begin
         vld_p2 <= pix_ok;
         fs_p2  <= pix_ok && (h_cur == '0) && (v_cur == '0);
         err_p2 <= timing_err;
         if (pix_ok) begin
            x_p2   <= h_cur;
            y_p2   <= v_cur;
            rgb_p2 <= rgb_p1;
         end
      end
   end

   assign pixValid   = vld_p2;
   assign pixX       = x_p2;
   assign pixY       = y_p2;
   assign pixRGB     = rgb_p2;
   assign frameStart = fs_p2;
   assign syncError  = err_p2;
   assign locked     = (state == ST_LOCKED);

endmodule
